// File: rtl/sd_read.sv
// sd_read: SPI-mode SD card single-block read engine. Sends CMD17, checks R1,
// waits for the 0xFE start token, then streams the sector out as 16-bit words.
module sd_read #(
  parameter int unsigned DATA_NUM      = 256,
  parameter int unsigned ACK_TIMEOUT   = 64,
  parameter int unsigned CMD_RETRY     = 8,
  parameter int unsigned TOKEN_TIMEOUT = 20000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        miso,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic        cs_n,
  output logic        mosi,
  output logic        rd_busy,
  output logic [15:0] rd_data,
  output logic        rd_data_en,
  output logic        rd_err
);

  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RTY_W = $clog2(CMD_RETRY + 1);
  localparam int unsigned TOK_W = $clog2(TOKEN_TIMEOUT + 1);
  localparam int unsigned WRD_W = ($clog2(DATA_NUM + 1) > 9) ? $clog2(DATA_NUM + 1) : 9;
  localparam logic [7:0]  CMD17 = 8'h51;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD17,
    CMD17_ACK,
    RD_WAIT,
    RD_DATA,
    RD_END
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [47:0]        cmd_sh_q, cmd_sh_d;
  logic [5:0]         cmd_cnt_q, cmd_cnt_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic               r1_on_q, r1_on_d;
  logic [6:0]         r1_sh_q, r1_sh_d;
  logic [2:0]         r1_cnt_q, r1_cnt_d;
  logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [WRD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [2:0]         end_cnt_q, end_cnt_d;
  logic [14:0]        sh_q, sh_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic [15:0]        data_q, data_d;
  logic               data_en_q, data_en_d;
  logic               err_q, err_d;
  logic               retry_fail;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cmd_sh_d   = cmd_sh_q;
    retry_d    = retry_q;
    r1_sh_d    = r1_sh_q;
    sh_d       = sh_q;
    cs_n_d     = cs_n_q;
    data_d     = data_q;
    // Counters default to zero so every state exit clears them.
    cmd_cnt_d  = '0;
    ack_cnt_d  = '0;
    r1_on_d    = 1'b0;
    r1_cnt_d   = '0;
    tok_cnt_d  = '0;
    bit_cnt_d  = '0;
    word_cnt_d = '0;
    end_cnt_d  = '0;
    mosi_d     = 1'b1;
    data_en_d  = 1'b0;
    err_d      = 1'b0;
    retry_fail = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_en) begin
          addr_d   = rd_addr;
          retry_d  = RTY_W'(1);
          cmd_sh_d = {CMD17, rd_addr, 8'hFF};
          cs_n_d   = 1'b0;
          state_d  = SEND_CMD17;
        end
      end

      SEND_CMD17: begin
        mosi_d    = cmd_sh_q[47];
        cmd_sh_d  = {cmd_sh_q[46:0], 1'b1};
        cmd_cnt_d = cmd_cnt_q + 6'd1;
        if (cmd_cnt_q == 6'd47) begin
          state_d = CMD17_ACK;
        end
      end

      CMD17_ACK: begin
        if (!r1_on_q) begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
          if (!miso) begin
            // First 0 is R1 bit 7; r1_sh keeps the bits seen so far, LSB newest.
            r1_on_d   = 1'b1;
            r1_sh_d   = '0;
            r1_cnt_d  = 3'd1;
            ack_cnt_d = '0;
          end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
            retry_fail = 1'b1;
          end
        end else begin
          r1_on_d  = 1'b1;
          r1_sh_d  = {r1_sh_q[5:0], miso};
          r1_cnt_d = r1_cnt_q + 3'd1;
          if (r1_cnt_q == 3'd7) begin
            r1_on_d = 1'b0;
            if ({r1_sh_q, miso} == 8'h00) begin
              state_d = RD_WAIT;
            end else begin
              retry_fail = 1'b1;
            end
          end
        end
      end

      RD_WAIT: begin
        if (!miso) begin
          state_d = RD_DATA;
        end else if (tok_cnt_q == TOK_W'(TOKEN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RD_END;
        end else begin
          tok_cnt_d = tok_cnt_q + TOK_W'(1);
        end
      end

      RD_DATA: begin
        sh_d       = {sh_q[13:0], miso};
        bit_cnt_d  = bit_cnt_q + 4'd1;
        word_cnt_d = word_cnt_q;
        if (bit_cnt_q == 4'hF) begin
          // Once all data words are out, the next 16 bits are CRC and are dropped.
          if (word_cnt_q == WRD_W'(DATA_NUM)) begin
            state_d = RD_END;
          end else begin
            data_d     = {sh_q, miso};
            data_en_d  = 1'b1;
            word_cnt_d = word_cnt_q + WRD_W'(1);
          end
        end
      end

      RD_END: begin
        end_cnt_d = end_cnt_q + 3'd1;
        if (end_cnt_q == 3'd7) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        cs_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    if (retry_fail) begin
      if (retry_q < RTY_W'(CMD_RETRY)) begin
        retry_d  = retry_q + RTY_W'(1);
        cmd_sh_d = {CMD17, addr_q, 8'hFF};
        state_d  = SEND_CMD17;
      end else begin
        err_d   = 1'b1;
        state_d = RD_END;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cmd_sh_q   <= '1;
      cmd_cnt_q  <= '0;
      retry_q    <= '0;
      ack_cnt_q  <= '0;
      r1_on_q    <= 1'b0;
      r1_sh_q    <= '0;
      r1_cnt_q   <= '0;
      tok_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      end_cnt_q  <= '0;
      sh_q       <= '0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b1;
      data_q     <= '0;
      data_en_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmd_sh_q   <= cmd_sh_d;
      cmd_cnt_q  <= cmd_cnt_d;
      retry_q    <= retry_d;
      ack_cnt_q  <= ack_cnt_d;
      r1_on_q    <= r1_on_d;
      r1_sh_q    <= r1_sh_d;
      r1_cnt_q   <= r1_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      end_cnt_q  <= end_cnt_d;
      sh_q       <= sh_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      err_q      <= err_d;
    end
  end

  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;
  assign rd_busy    = (state_q != IDLE);
  assign rd_data    = data_q;
  assign rd_data_en = data_en_q;
  assign rd_err     = err_q;

endmodule

// File: tb/tb_sd_read.sv
// Bench for sd_read: a behavioural SD card answers CMD17 frames from a per-test
// script; a monitor checks every word strobe against the expected sector.
module tb_sd_read;

  localparam int unsigned DATA_NUM      = 256;
  localparam int unsigned ACK_TIMEOUT   = 64;
  localparam int unsigned CMD_RETRY     = 8;
  localparam int unsigned TOKEN_TIMEOUT = 20000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        miso    = 1'b1;
  logic        rd_en   = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        cs_n, mosi, rd_busy, rd_data_en, rd_err;
  logic [15:0] rd_data;

  sd_read #(
    .DATA_NUM     (DATA_NUM),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .CMD_RETRY    (CMD_RETRY),
    .TOKEN_TIMEOUT(TOKEN_TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .miso      (miso),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .rd_busy   (rd_busy),
    .rd_data   (rd_data),
    .rd_data_en(rd_data_en),
    .rd_err    (rd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Card script for the current request.
  int          r1_plan[$];
  int unsigned n_idle, n_gap;
  bit          tok_never;
  logic [15:0] words[DATA_NUM];
  logic [15:0] crc;
  logic [31:0] exp_addr;

  bit          resp_q[$];
  bit          lst_on = 1'b0;
  int unsigned lst_n;
  logic [47:0] lst_sh;
  int unsigned frames;
  int unsigned frame_cyc[$];
  int unsigned r1_end_cyc;

  function automatic void push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) resp_q.push_back(v[i]);
  endfunction

  function automatic void respond(input int idx);
    int v;
    v = (idx < r1_plan.size()) ? r1_plan[idx] : -1;
    if (v < 0) return;
    for (int b = 0; b < int'(n_idle); b++) push_bits(16'hFF, 8);
    push_bits(16'(v), 8);
    r1_end_cyc = cyc + resp_q.size() - 1;
    if (v == 0 && !tok_never) begin
      for (int b = 0; b < int'(n_gap); b++) push_bits(16'hFF, 8);
      push_bits(16'hFE, 8);
      for (int w = 0; w < int'(DATA_NUM); w++) push_bits(words[w], 16);
      push_bits(crc, 16);
    end
  endfunction

  // Card: decode CMD17 on mosi, answer on miso one bit per cycle from the queue.
  always @(negedge sys_clk) begin
    if (sys_rst || cs_n !== 1'b0) begin
      lst_on = 1'b0;
      resp_q.delete();
      miso = 1'b1;
    end else begin
      if (!lst_on && mosi === 1'b0) begin
        lst_on = 1'b1;
        lst_n  = 0;
        frame_cyc.push_back(cyc);
      end
      if (lst_on) begin
        lst_sh = {lst_sh[46:0], mosi};
        lst_n++;
        if (lst_n == 48) begin
          lst_on = 1'b0;
          frames++;
          chk("cmd17_frame", lst_sh, {8'h51, exp_addr, 8'hFF});
          respond(int'(frames) - 1);
        end
      end
      miso = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b1;
    end
  end

  int unsigned strobes, errs, err_cyc, last_strobe_cyc, overlap;
  logic [15:0] exp_q[$];

  always @(negedge sys_clk) begin
    if (rd_data_en === 1'b1) begin
      chk("strobe_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk($sformatf("word%0d", strobes), rd_data, exp_q.pop_front());
      if (strobes % DATA_NUM != 0) chk("strobe_spacing", cyc - last_strobe_cyc, 16);
      last_strobe_cyc = cyc;
      strobes++;
    end
    if (rd_err === 1'b1) begin
      errs++;
      err_cyc = cyc;
    end
    if (rd_err === 1'b1 && rd_data_en === 1'b1) overlap++;
  end

  int unsigned accept_cyc;

  task automatic setup_card(input bit counting);
    for (int i = 0; i < int'(DATA_NUM); i++) words[i] = counting ? 16'(i) : 16'($urandom);
    crc       = counting ? 16'hABCD : 16'($urandom);
    n_idle    = counting ? 2 : $urandom_range(0, 6);
    n_gap     = counting ? 3 : $urandom_range(0, 40);
    tok_never = 1'b0;
  endtask

  task automatic expect_words();
    for (int i = 0; i < int'(DATA_NUM); i++) exp_q.push_back(words[i]);
  endtask

  task automatic start_read(input logic [31:0] addr);
    @(negedge sys_clk);
    strobes = 0; errs = 0; overlap = 0; frames = 0;
    frame_cyc.delete();
    exp_addr = addr;
    rd_en    = 1'b1;
    rd_addr  = addr;
    @(negedge sys_clk);
    accept_cyc = cyc;
    rd_en      = 1'b0;
    rd_addr    = $urandom;
    chk("cs_n_low_after_accept", cs_n, 1'b0);
    chk("busy_after_accept", rd_busy, 1'b1);
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned n = 0;
    while (rd_busy === 1'b1 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    chk("read_completes_in_budget", rd_busy, 1'b0);
  endtask

  task automatic wait_strobes(input int unsigned target);
    int unsigned n = 0;
    while (strobes < target && n < 8000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("reached_word_target", strobes >= target, 1'b1);
  endtask

  task automatic end_checks(input int unsigned e_strobes, input int unsigned e_errs,
                            input int unsigned e_frames);
    chk("strobe_count", strobes, e_strobes);
    chk("err_count", errs, e_errs);
    chk("frame_count", frames, e_frames);
    chk("words_left", exp_q.size(), 0);
    chk("err_data_overlap", overlap, 0);
    chk("cs_n_idle", cs_n, 1'b1);
    chk("mosi_idle", mosi, 1'b1);
    if (frame_cyc.size() > 0) chk("first_frame_latency", frame_cyc[0] - accept_cyc, 1);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned s;

    // Reset values.
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_busy", rd_busy, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_data_en", rd_data_en, 1'b0);
    chk("rst_err", rd_err, 1'b0);
    sys_rst = 1'b0;

    // Nominal read, counting pattern.
    setup_card(1'b1);
    r1_plan = '{0};
    exp_q.delete();
    expect_words();
    start_read(32'h0000_1234);
    wait_idle(6000);
    end_checks(DATA_NUM, 0, 1);
    chk("cs_n_rise_after_crc", cyc - last_strobe_cyc, 24);

    // R1 retry: 0x04 then 0x00.
    setup_card(1'b0);
    r1_plan = '{4, 0};
    expect_words();
    start_read($urandom);
    wait_idle(7000);
    end_checks(DATA_NUM, 0, 2);

    // R1 timeout exhaustion.
    r1_plan.delete();
    start_read($urandom);
    wait_idle(2000);
    end_checks(0, 1, CMD_RETRY);
    for (int i = 1; i < frame_cyc.size(); i++)
      chk("frame_period", frame_cyc[i] - frame_cyc[i-1], 48 + ACK_TIMEOUT);
    if (frame_cyc.size() > 0)
      chk("ack_timeout_err_time", err_cyc - frame_cyc[frame_cyc.size()-1], 47 + ACK_TIMEOUT);
    chk("end_after_err", cyc - err_cyc, 8);

    // Token timeout.
    setup_card(1'b0);
    tok_never = 1'b1;
    r1_plan = '{0};
    start_read($urandom);
    wait_idle(TOKEN_TIMEOUT + 1000);
    end_checks(0, 1, 1);
    chk("token_timeout_err_time", err_cyc - r1_end_cyc, TOKEN_TIMEOUT + 1);
    chk("end_after_token_err", cyc - err_cyc, 8);

    // Reset after word 100, then a clean read.
    setup_card(1'b0);
    r1_plan = '{0};
    expect_words();
    start_read($urandom);
    wait_strobes(100);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_mosi", mosi, 1'b1);
    chk("midrst_busy", rd_busy, 1'b0);
    chk("midrst_data_en", rd_data_en, 1'b0);
    chk("midrst_rd_data", rd_data, 16'h0000);
    sys_rst = 1'b0;
    s = strobes;
    repeat (40) @(negedge sys_clk);
    chk("no_strobe_after_reset", strobes, s);
    chk("no_err_after_reset", errs, 0);
    exp_q.delete();
    setup_card(1'b0);
    r1_plan = '{0};
    expect_words();
    start_read($urandom);
    wait_idle(6000);
    end_checks(DATA_NUM, 0, 1);

    // Request while busy is ignored.
    setup_card(1'b0);
    r1_plan = '{0};
    expect_words();
    a = $urandom;
    start_read(a);
    wait_strobes(10);
    rd_en   = 1'b1;
    rd_addr = a ^ 32'hFFFF_0000;
    @(negedge sys_clk);
    rd_en = 1'b0;
    wait_idle(6000);
    end_checks(DATA_NUM, 0, 1);

    // rd_en held through completion restarts right after IDLE.
    setup_card(1'b0);
    r1_plan = '{0, 0};
    expect_words();
    expect_words();
    a = $urandom;
    start_read(a);
    rd_en   = 1'b1;
    rd_addr = a;
    wait_idle(6000);
    @(negedge sys_clk);
    chk("held_rd_en_restarts", rd_busy, 1'b1);
    rd_en = 1'b0;
    wait_idle(6000);
    end_checks(2 * DATA_NUM, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", n_pass, n_total);
    $fatal(1, "time limit");
  end

endmodule
